dmem_port_arbiter: RTL

//  Shares the single-port data RAM between the RISC-V memory stage (CPU port) and the filter

---
 rtl/dmem_arb_pkg.sv | 20 ++
 rtl/dmem_port_arbiter_rr_arb2.sv | 43 ++++
 rtl/dmem_port_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-RAM port arbiter.
package dmem_arb_pkg;

   typedef enum logic {
      ST_ARB  = 1'b0,
      ST_LOCK = 1'b1
   } arb_state_e;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_FLT = 1'b1;

   localparam int DATA_W_DEF = 32;

   function automatic int be_width(input int data_w);
      return data_w / 8;
   endfunction

   localparam int BE_W = be_width(DATA_W_DEF);

endpackage

// File: rtl/dmem_port_arbiter_rr_arb2.sv
// Two-way round-robin picker; remembers the last winner and favours the other side on a tie.
module rr_arb2
   import dmem_arb_pkg::*;
(
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_req_cpu,
   input  logic i_req_flt,
   input  logic i_prio_cpu,
   input  logic i_upd,
   input  logic i_upd_idx,
   input  logic i_set_last_flt,
   output logic o_valid,
   output logic o_idx
);

   logic r_last;

   always_comb begin
      o_valid = i_req_cpu | i_req_flt;
      if (i_req_cpu && i_req_flt) begin
         o_idx = i_prio_cpu ? PORT_CPU : ~r_last;
      end else if (i_req_flt) begin
         o_idx = PORT_FLT;
      end else begin
         o_idx = PORT_CPU;
      end
   end

   // A real grant always wins over the lock-exit preset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_last <= PORT_CPU;
      end else if (i_upd) begin
         r_last <= i_upd_idx;
      end else if (i_set_last_flt) begin
         r_last <= PORT_FLT;
      end else begin
         r_last <= r_last;
      end
   end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-port data RAM between the CPU memory stage and the filter stream,
// with filter burst lock and a bounded CPU wait.
module dmem_port_arbiter
   import dmem_arb_pkg::*;
#(
   parameter  int MEM_WORDS    = 1024,
   parameter  int DATA_W       = 32,
   parameter  int STARVE_LIMIT = 8,
   localparam int AW           = $clog2(MEM_WORDS),
   localparam int BW           = be_width(DATA_W),
   localparam int CW           = $clog2(STARVE_LIMIT + 1)
)(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_cpu_req,
   input  logic              i_cpu_we,
   input  logic [31:0]       i_cpu_addr,
   input  logic [DATA_W-1:0] i_cpu_wdata,
   input  logic [BW-1:0]     i_cpu_be,
   output logic              o_cpu_gnt,
   output logic              o_cpu_rvalid,
   output logic [DATA_W-1:0] o_cpu_rdata,
   input  logic              i_flt_req,
   input  logic              i_flt_we,
   input  logic [31:0]       i_flt_addr,
   input  logic [DATA_W-1:0] i_flt_wdata,
   input  logic [BW-1:0]     i_flt_be,
   input  logic              i_flt_lock,
   output logic              o_flt_gnt,
   output logic              o_flt_rvalid,
   output logic [DATA_W-1:0] o_flt_rdata,
   output logic              o_mem_en,
   output logic [BW-1:0]     o_mem_we,
   output logic [AW-1:0]     o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata,
   output logic              o_err_oob
);

   arb_state_e        r_state;
   logic [CW-1:0]     r_wait;
   logic              r_pend;
   logic              r_pend_owner;
   logic              r_pend_oob;
   logic              r_err;
   logic [DATA_W-1:0] r_cpu_rdata;
   logic [DATA_W-1:0] r_flt_rdata;

   logic              w_locked, w_exit, w_starve;
   logic              w_pick_valid, w_pick_idx;
   logic              w_cpu_gnt, w_flt_gnt, w_gnt;
   logic              w_sel_we, w_oob;
   logic [31:0]       w_sel_addr;
   logic [DATA_W-1:0] w_sel_wdata;
   logic [BW-1:0]     w_sel_be;
   logic [DATA_W-1:0] w_rd_value;
   logic              w_cpu_rvalid, w_flt_rvalid;

   assign w_locked = (r_state == ST_LOCK) & i_flt_lock;
   assign w_exit   = (r_state == ST_LOCK) & ~i_flt_lock;
   assign w_starve = w_locked & i_cpu_req & (r_wait == CW'(STARVE_LIMIT));

   rr_arb2 u_rr (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_req_cpu      (i_cpu_req),
      .i_req_flt      (i_flt_req),
      .i_prio_cpu     (w_exit),
      .i_upd          (w_gnt),
      .i_upd_idx      (w_flt_gnt),
      .i_set_last_flt (w_exit),
      .o_valid        (w_pick_valid),
      .o_idx          (w_pick_idx)
   );

   // While locked the filter owns the port except for the one forced CPU slot.
   always_comb begin
      if (i_rst) begin
         w_cpu_gnt = 1'b0;
         w_flt_gnt = 1'b0;
      end else if (w_locked) begin
         w_cpu_gnt = w_starve;
         w_flt_gnt = i_flt_req & ~w_starve;
      end else begin
         w_cpu_gnt = w_pick_valid & (w_pick_idx == PORT_CPU);
         w_flt_gnt = w_pick_valid & (w_pick_idx == PORT_FLT);
      end
   end

   assign w_gnt = w_cpu_gnt | w_flt_gnt;

   always_comb begin
      if (w_flt_gnt) begin
         w_sel_we    = i_flt_we;
         w_sel_addr  = i_flt_addr;
         w_sel_wdata = i_flt_wdata;
         w_sel_be    = i_flt_be;
      end else begin
         w_sel_we    = i_cpu_we;
         w_sel_addr  = i_cpu_addr;
         w_sel_wdata = i_cpu_wdata;
         w_sel_be    = i_cpu_be;
      end
   end

   assign w_oob       = w_sel_addr >= 32'(MEM_WORDS * 4);
   assign o_cpu_gnt   = w_cpu_gnt;
   assign o_flt_gnt   = w_flt_gnt;
   assign o_mem_en    = w_gnt & ~w_oob;
   assign o_mem_we    = (o_mem_en & w_sel_we) ? w_sel_be : {BW{1'b0}};
   assign o_mem_addr  = w_sel_addr[AW+1:2];
   assign o_mem_wdata = w_sel_wdata;

   // Out-of-range reads return zero instead of whatever the RAM last produced.
   assign w_rd_value   = r_pend_oob ? {DATA_W{1'b0}} : i_mem_rdata;
   assign w_cpu_rvalid = ~i_rst & r_pend & (r_pend_owner == PORT_CPU);
   assign w_flt_rvalid = ~i_rst & r_pend & (r_pend_owner == PORT_FLT);
   assign o_cpu_rvalid = w_cpu_rvalid;
   assign o_flt_rvalid = w_flt_rvalid;
   assign o_cpu_rdata  = i_rst ? {DATA_W{1'b0}} : (w_cpu_rvalid ? w_rd_value : r_cpu_rdata);
   assign o_flt_rdata  = i_rst ? {DATA_W{1'b0}} : (w_flt_rvalid ? w_rd_value : r_flt_rdata);
   assign o_err_oob    = r_err;

   // Lock FSM, CPU wait counter, read-return pipeline and sticky error.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= ST_ARB;
         r_wait       <= {CW{1'b0}};
         r_pend       <= 1'b0;
         r_pend_owner <= PORT_CPU;
         r_pend_oob   <= 1'b0;
         r_err        <= 1'b0;
         r_cpu_rdata  <= {DATA_W{1'b0}};
         r_flt_rdata  <= {DATA_W{1'b0}};
      end else begin
         case (r_state)
            ST_ARB:  r_state <= (w_flt_gnt & i_flt_lock) ? ST_LOCK : ST_ARB;
            ST_LOCK: r_state <= i_flt_lock ? ST_LOCK : ST_ARB;
            default: r_state <= ST_ARB;
         endcase

         if (w_cpu_gnt) begin
            r_wait <= {CW{1'b0}};
         end else if (i_cpu_req && (r_wait != CW'(STARVE_LIMIT))) begin
            r_wait <= r_wait + CW'(1);
         end else begin
            r_wait <= r_wait;
         end

         r_pend       <= w_gnt & ~w_sel_we;
         r_pend_owner <= w_flt_gnt;
         r_pend_oob   <= w_oob;

         if (w_cpu_rvalid) r_cpu_rdata <= w_rd_value;
         if (w_flt_rvalid) r_flt_rdata <= w_rd_value;
         if (w_gnt & w_oob) r_err <= 1'b1;
      end
   end

endmodule
